// File: rtl/tl_sensor_cond_if.sv
// Sensor-side bundle of the conditioning stage: raw loop inputs, counter clear, clean outputs.
// Latency: none (wires only).
// Backpressure: none; every signal is a free-running level.
interface tl_sensor_cond_if #(
    parameter int CNT_W = 8
);
    logic             sa_raw;
    logic             sb_raw;
    logic             clr_cnt;
    logic             Ta;
    logic             Tb;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport master (
        output sa_raw, sb_raw, clr_cnt,
        input  Ta, Tb, cnt_a, cnt_b
    );

    modport slave (
        input  sa_raw, sb_raw, clr_cnt,
        output Ta, Tb, cnt_a, cnt_b
    );
endinterface

// File: rtl/tl_sensor_cond.sv
// Two-lane loop-sensor conditioner: synchronize, debounce, hold presence, count arrivals.
// Latency: raw rise -> T rise in 3+DB_CYCLES edges; T held HOLD_CYCLES after debounced fall.
// Backpressure: none; inputs are sampled every cycle, outputs are registered levels.
module tl_sensor_cond #(
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    tl_sensor_cond_if.slave   bus
);
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] PRESENT = 2'b01;
    localparam logic [1:0] HOLD    = 2'b10;

    localparam logic [7:0]       DB_LAST   = 8'(DB_CYCLES - 1);
    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Lane 0 is street A, lane 1 is street B.
    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       db;
    logic [1:0]       db_nxt;
    logic [1:0]       db_rise;
    logic [1:0]       t_q;
    logic [7:0]       db_cnt       [2];
    logic [7:0]       db_cnt_nxt   [2];
    logic [7:0]       hold_cnt     [2];
    logic [7:0]       hold_cnt_nxt [2];
    logic [1:0]       state        [2];
    logic [1:0]       state_nxt    [2];
    logic [CNT_W-1:0] cnt          [2];

    assign raw = {bus.sb_raw, bus.sa_raw};

    // Debounce decision and presence FSM next-state for both lanes.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_nxt[i]       = db[i];
            db_cnt_nxt[i]   = 8'd0;
            hold_cnt_nxt[i] = hold_cnt[i];
            state_nxt[i]    = state[i];
            if (s2[i] != db[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    db_nxt[i] = s2[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + 8'd1;
                end
            end
            db_rise[i] = db_nxt[i] & ~db[i];
            // The FSM looks at the registered db, so T lags db by one edge.
            case (state[i])
                IDLE: begin
                    if (db[i]) state_nxt[i] = PRESENT;
                end
                PRESENT: begin
                    if (!db[i]) begin
                        state_nxt[i]    = HOLD;
                        hold_cnt_nxt[i] = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (db[i]) begin
                        state_nxt[i] = PRESENT;
                    end else if (hold_cnt[i] == 8'd0) begin
                        state_nxt[i] = IDLE;
                    end else begin
                        hold_cnt_nxt[i] = hold_cnt[i] - 8'd1;
                    end
                end
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    // Synchronizers, debouncer, FSM and registered presence outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1  <= 2'b00;
            s2  <= 2'b00;
            db  <= 2'b00;
            t_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i]   <= 8'd0;
                hold_cnt[i] <= 8'd0;
                state[i]    <= IDLE;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            db <= db_nxt;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i]   <= db_cnt_nxt[i];
                hold_cnt[i] <= hold_cnt_nxt[i];
                state[i]    <= state_nxt[i];
                t_q[i]      <= (state_nxt[i] != IDLE);
            end
        end
    end

    // Saturating arrival counters; a clear on the arrival edge leaves a count of one.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else if (bus.clr_cnt) begin
                cnt[i] <= db_rise[i] ? CNT_ONE : '0;
            end else if (db_rise[i] && (cnt[i] != CNT_MAX)) begin
                cnt[i] <= cnt[i] + CNT_ONE;
            end
        end
    end

    assign bus.Ta    = t_q[0];
    assign bus.Tb    = t_q[1];
    assign bus.cnt_a = cnt[0];
    assign bus.cnt_b = cnt[1];
endmodule

// File: tb/tb_tl_sensor_cond.sv
// Directed and random stimulus for the sensor conditioner against a windowed reference model.
// Latency: checks one cycle's outputs #1 after each rising edge.
// Backpressure: none.
module tb_tl_sensor_cond;
    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    tl_sensor_cond_if #(.CNT_W(CW)) bus ();

    tl_sensor_cond #(
        .DB_CYCLES   (DB),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: db flips once the last DB synchronized samples all disagree with it;
    // T is db delayed one edge, stretched HOLD edges past the most recent db fall.
    bit          m_r1   [2];
    bit          m_r2   [2];
    bit          m_db   [2];
    bit          m_t    [2];
    logic [DB-1:0] m_win [2];
    bit          m_fv   [2];
    int          m_fall [2];
    int          m_cnt  [2];
    int          ecount;

    task automatic model_edge(input bit ra, input bit rb, input bit clr, input bit rst);
        bit raw_l;
        bit t_new;
        bit rise;
        ecount++;
        for (int l = 0; l < 2; l++) begin
            raw_l = (l == 0) ? ra : rb;
            if (rst) begin
                m_r1[l] = 0; m_r2[l] = 0; m_db[l] = 0; m_t[l] = 0;
                m_win[l] = '0; m_fv[l] = 0; m_fall[l] = 0; m_cnt[l] = 0;
            end else begin
                t_new = m_db[l] || (m_fv[l] && (ecount <= m_fall[l] + HOLD));
                m_win[l] = {m_win[l][DB-2:0], m_r2[l]};
                rise = 0;
                if (m_win[l] == (m_db[l] ? {DB{1'b0}} : {DB{1'b1}})) begin
                    m_db[l] = ~m_db[l];
                    if (m_db[l]) begin
                        rise = 1;
                    end else begin
                        m_fv[l]   = 1;
                        m_fall[l] = ecount;
                    end
                end
                if (clr)                      m_cnt[l] = rise ? 1 : 0;
                else if (rise && m_cnt[l] < CMAX) m_cnt[l] = m_cnt[l] + 1;
                m_r2[l] = m_r1[l];
                m_r1[l] = raw_l;
                m_t[l]  = t_new;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d at edge %0d", tag, obs, exp, ecount);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare outputs after the edge.
    task automatic step(input bit ra, input bit rb, input bit clr, input bit rst);
        bus.sa_raw  = ra;
        bus.sb_raw  = rb;
        bus.clr_cnt = clr;
        reset       = rst;
        @(posedge clk);
        model_edge(ra, rb, clr, rst);
        #1;
        check("Ta",    {31'd0, bus.Ta},      {31'd0, m_t[0]});
        check("Tb",    {31'd0, bus.Tb},      {31'd0, m_t[1]});
        check("cnt_a", {29'd0, bus.cnt_a},   32'(m_cnt[0]));
        check("cnt_b", {29'd0, bus.cnt_b},   32'(m_cnt[1]));
    endtask

    initial begin
        bit ra;
        bit rb;
        int la;
        int lb;
        total  = 0;
        bad    = 0;
        ecount = 0;
        bus.sa_raw = 0; bus.sb_raw = 0; bus.clr_cnt = 0; reset = 1;

        // Reset with both sensors high, then release: Ta rises on the 7th edge.
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        check("rst_Ta", {31'd0, bus.Ta}, 32'd0);
        check("rst_cnt_a", {29'd0, bus.cnt_a}, 32'd0);
        for (int k = 1; k <= 7; k++) begin
            step(1, 1, 0, 0);
            check("rise_latency_Ta", {31'd0, bus.Ta}, (k == 7) ? 32'd1 : 32'd0);
        end
        check("first_arrival_cnt_a", {29'd0, bus.cnt_a}, 32'd1);

        // Settle low and clear, then a 3-cycle glitch that must be ignored.
        repeat (25) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0);
        repeat (20) begin
            step(0, 0, 0, 0);
            check("glitch_Ta", {31'd0, bus.Ta}, 32'd0);
        end
        check("glitch_cnt_a", {29'd0, bus.cnt_a}, 32'd0);

        // A 4-cycle pulse is accepted; Ta lasts through the hold then drops.
        for (int k = 1; k <= 7; k++) begin
            step((k <= 4), 0, 0, 0);
            check("pulse_rise_Ta", {31'd0, bus.Ta}, (k == 7) ? 32'd1 : 32'd0);
        end
        repeat (20) step(0, 0, 0, 0);
        check("pulse_cnt_a", {29'd0, bus.cnt_a}, 32'd1);
        check("pulse_fall_Ta", {31'd0, bus.Ta}, 32'd0);

        // Hold extension on B: 20 high, 5 low, high again keeps Tb up, two arrivals.
        step(0, 0, 1, 0);
        repeat (20) step(0, 1, 0, 0);
        repeat (5) begin
            step(0, 0, 0, 0);
            check("hold_ext_Tb", {31'd0, bus.Tb}, 32'd1);
        end
        repeat (10) begin
            step(0, 1, 0, 0);
            check("hold_ext_Tb", {31'd0, bus.Tb}, 32'd1);
        end
        check("hold_ext_cnt_b", {29'd0, bus.cnt_b}, 32'd2);
        repeat (25) step(0, 0, 0, 0);

        // Nine clean arrivals on A saturate a 3-bit counter.
        step(0, 0, 1, 0);
        for (int n = 0; n < 9; n++) begin
            repeat ($urandom_range(9, 4)) step(1, 0, 0, 0);
            repeat ($urandom_range(9, 4)) step(0, 0, 0, 0);
        end
        repeat (8) step(0, 0, 0, 0);
        check("sat_cnt_a", {29'd0, bus.cnt_a}, 32'(CMAX));

        // Clear on the same edge that db rises: clear, then count.
        repeat (5) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("clr_on_rise_cnt_a", {29'd0, bus.cnt_a}, 32'd1);
        repeat (30) step(0, 0, 0, 0);

        // Lane independence: A chatters every cycle, B is clean high.
        step(0, 0, 1, 0);
        for (int k = 0; k < 30; k++) step(k[0], 1, 0, 0);
        check("indep_Ta", {31'd0, bus.Ta}, 32'd0);
        check("indep_cnt_a", {29'd0, bus.cnt_a}, 32'd0);
        check("indep_Tb", {31'd0, bus.Tb}, 32'd1);
        check("indep_cnt_b", {29'd0, bus.cnt_b}, 32'd1);
        repeat (25) step(0, 0, 0, 0);

        // Reset three cycles into a hold on A clears Ta at once and it stays low.
        repeat (10) step(1, 0, 0, 0);
        repeat (9) step(0, 0, 0, 0);
        check("pre_reset_hold_Ta", {31'd0, bus.Ta}, 32'd1);
        step(0, 0, 0, 1);
        check("mid_hold_reset_Ta", {31'd0, bus.Ta}, 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        repeat (20) begin
            step(0, 0, 0, 0);
            check("post_reset_Ta", {31'd0, bus.Ta}, 32'd0);
        end

        // Random run lengths on both lanes with occasional clears and resets.
        ra = 0; rb = 0; la = 0; lb = 0;
        repeat (600) begin
            if (la == 0) begin ra = ~ra; la = $urandom_range(12, 1); end
            if (lb == 0) begin rb = ~rb; lb = $urandom_range(12, 1); end
            la--; lb--;
            step(ra, rb, ($urandom_range(24, 0) == 0), ($urandom_range(299, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
